iob_timer_alarm: RTL and testbench
==================================

Name: iob_timer_alarm

Overview:
- Multi-channel alarm scheduler for the free-running 64-bit timer count.
- Holds N_CH programmable deadlines and periods.
- Time-shares one 64-bit comparator/adder across channels in round-robin.
- Raises per-channel pending interrupts. Sits beside the timer core; the timer count is an input, and channel programming comes from the software register file.

Parameters:
- N_CH, 4, number of alarm channels (2..16)
- CNT_W, 64, timer count / deadline / period width
- CH_W, $clog2(N_CH), channel index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- en  in  1  scan enable; 0 freezes the scan pointer and FSM, config is still accepted
- timer_value  in  CNT_W  current timer count
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_ch  in  CH_W  target channel
- cfg_op  in  2  00 disarm, 01 arm, 10 clear miss count, 11 reserved (no-op, accepted)
- cfg_deadline  in  CNT_W  absolute first-fire time
- cfg_period  in  CNT_W  reload period; 0 = one-shot
- irq_ack  in  N_CH  per-channel pending clear, level, sampled each cycle
- irq_pending  out  N_CH  per-channel pending flags
- irq  out  1  OR of irq_pending, registered
- armed  out  N_CH  per-channel armed flags
- miss_cnt  out  8*N_CH  present only with the optional feature

Behaviour:
- Reset: all outputs 0 except cfg_ready=1. State is CMP, ptr=0, all deadlines/periods 0, armed=0, pending=0.
- FSM: CMP -> UPD -> CMP.
  - With en=0, stays in CMP; ptr and all scan state are frozen.
  - In CMP: read channel ptr and register diff = timer_value - deadline[ptr] (mod 2^CNT_W); hit = armed[ptr] & ~diff[CNT_W-1].
  - In UPD:
    - If hit: pending[ptr] <= 1.
    - If hit and period != 0: deadline <= deadline + period (mod 2^CNT_W).
    - If hit and period == 0: armed[ptr] <= 0.
    - In all cases ptr <= (ptr == N_CH-1) ? 0 : ptr+1.
- Wrap-safe compare: a deadline counts as reached when it lies within the past 2^(CNT_W-1) counts. Deadline additions wrap silently.
- Handshake:
  - cfg_ready = (state == CMP).
  - A transfer happens on cfg_valid & cfg_ready and takes effect at the end of that cycle.
  - In a transfer cycle the scan compare is suppressed: stay in CMP with ptr unchanged; the scan resumes next cycle.
  - cfg_valid may be held; the request is accepted on the first CMP cycle.
- Arm: writes deadline and period and sets armed. pending is untouched.
- Disarm: clears armed only; stored deadline and period are kept.
- Fire latency: a channel is checked at least once every 2*N_CH enabled cycles with no config traffic. irq rises 1 cycle after the UPD that sets pending.
- Catch-up: if a reloaded deadline is still in the past, the channel fires again on its next visit. No skipping.
- Simultaneous events:
  - Set and irq_ack on the same channel in the same cycle: pending stays 1 (set wins).
  - A config to channel ptr arriving in CMP suppresses that cycle's check, so there is no read/write race on channel registers.
- Reset asserted mid-operation: immediate return to reset state; an in-flight UPD is discarded.

Optional Feature:
- Macro: IOB_TIMER_ALARM_MISSCNT_EN.
- With the macro:
  - Each channel has an 8-bit saturating counter, incremented in UPD when hit occurs while pending is already 1 and not acked in that same cycle.
  - Saturates at 255; cleared by cfg_op=10 or reset.
  - Exposed on miss_cnt, channel c at bits [8c+7:8c].
- Without the macro: no miss_cnt port, no counters, and cfg_op=10 is an accepted no-op.

Decomposition:
- Shared header iob_timer_alarm.vh:
  - op encodings ALARM_OP_DISARM/ARM/CLRMISS
  - FSM state encodings ALARM_ST_CMP/UPD
  - ALARM_MISS_W=8
- Sub-module iob_timer_alarm_cmp: combinational wrap-safe reached test plus next-deadline adder, instantiated once and shared by all channels.
- Channel storage and scan FSM stay in the top module, built from iob_reg-style registers.

Test Plan:
- N_CH=4. Arm ch2 with deadline=100, period=0; ramp timer_value +1/cycle from 0 -> pending[2] set once, within 8 cycles of timer_value reaching 100; armed[2] drops; no second fire by timer_value 1000.
- Arm ch0 with deadline=50, period=20; ramp timer from 0; ack each fire -> fires near 50, 70, 90, 110; armed[0] stays 1.
- Arm ch1 with deadline=2^64-10, period=30, timer starting at 2^64-20 -> fires when timer reaches 2^64-10, next deadline 20 (wrapped), then fires near 20.
- Hold cfg_valid for 3 cycles during a scan -> exactly one transfer, accepted only in a CMP cycle; ptr does not advance in the transfer cycle.
- irq_ack[3] asserted in the same cycle ch3's pending is set -> pending[3]=1 afterwards; irq=1.
- With IOB_TIMER_ALARM_MISSCNT_EN: ch0 deadline=0, period=1, timer frozen at 1000, never acked -> miss_cnt[7:0] climbs and saturates at 255; cfg_op=10 on ch0 -> 0.

Source files
------------

// File: rtl/iob_timer_alarm_pkg.sv
// Shared encodings for the iob_timer_alarm channel scheduler: config opcodes,
// scan FSM states and the miss-counter width with its saturating increment.
package iob_timer_alarm_pkg;

  localparam logic [1:0] ALARM_OP_DISARM  = 2'b00;
  localparam logic [1:0] ALARM_OP_ARM     = 2'b01;
  localparam logic [1:0] ALARM_OP_CLRMISS = 2'b10;

  localparam int ALARM_MISS_W = 8;

  typedef enum logic {
    ALARM_ST_CMP = 1'b0,
    ALARM_ST_UPD = 1'b1
  } alarm_state_e;

  function automatic logic [ALARM_MISS_W-1:0] sat_inc(input logic [ALARM_MISS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// Shared datapath for the alarm scan: wrap-safe "deadline reached" test and the
// periodic reload adder. One instance serves every channel via the scan pointer.
module iob_timer_alarm_cmp #(
  parameter int CNT_W = 64
) (
  input  logic [CNT_W-1:0] timer_value,
  input  logic [CNT_W-1:0] deadline,
  input  logic [CNT_W-1:0] period,
  output logic             reached,
  output logic [CNT_W-1:0] next_deadline
);

  logic [CNT_W-1:0] diff;

  // Reached when the deadline lies within the past half of the count space.
  assign diff          = timer_value - deadline;
  assign reached       = ~diff[CNT_W-1];
  assign next_deadline = deadline + period;

endmodule

// File: rtl/iob_timer_alarm.sv
// Multi-channel alarm scheduler: round-robin CMP/UPD scan over N_CH deadlines
// sharing one comparator/adder. Optional per-channel miss counters are built
// when IOB_TIMER_ALARM_MISSCNT_EN is defined.
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 64,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CNT_W-1:0]             timer_value,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [1:0]                   cfg_op,
  input  logic [CNT_W-1:0]             cfg_deadline,
  input  logic [CNT_W-1:0]             cfg_period,
  input  logic [N_CH-1:0]              irq_ack,
  output logic [N_CH-1:0]              irq_pending,
  output logic                         irq,
  output logic [N_CH-1:0]              armed
`ifdef IOB_TIMER_ALARM_MISSCNT_EN
  ,
  output logic [ALARM_MISS_W*N_CH-1:0] miss_cnt
`endif
);

  // Config handshake: a transfer is cfg_valid & cfg_ready, ready only in CMP,
  // and it lands at the end of that cycle; the scan does not step that cycle.

  alarm_state_e     state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             hit_q;
  logic             upd;
  logic             cfg_fire;
  logic             fire;
  logic             reached;
  logic [CNT_W-1:0] next_deadline;
  logic [CNT_W-1:0] cur_deadline, cur_period;
  logic [CNT_W-1:0] deadline_q [N_CH];
  logic [CNT_W-1:0] period_q   [N_CH];
  logic [N_CH-1:0]  armed_q, armed_d;
  logic [N_CH-1:0]  pending_q, pending_d;
  logic             irq_q;

  assign cfg_ready    = (state_q == ALARM_ST_CMP);
  assign cfg_fire     = cfg_valid & cfg_ready;
  assign cur_deadline = deadline_q[ptr_q];
  assign cur_period   = period_q[ptr_q];
  assign fire         = upd & hit_q;

  iob_timer_alarm_cmp #(.CNT_W(CNT_W)) u_cmp (
    .timer_value   (timer_value),
    .deadline      (cur_deadline),
    .period        (cur_period),
    .reached       (reached),
    .next_deadline (next_deadline)
  );

  // en only gates the CMP->UPD step; an UPD already under way always completes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    upd     = 1'b0;
    case (state_q)
      ALARM_ST_CMP: if (en && !cfg_fire) state_d = ALARM_ST_UPD;
      ALARM_ST_UPD: begin
        upd     = 1'b1;
        state_d = ALARM_ST_CMP;
        ptr_d   = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
      end
      default: state_d = ALARM_ST_CMP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALARM_ST_CMP;
      ptr_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == ALARM_ST_CMP) hit_q <= armed_q[ptr_q] & reached;
    end
  end

  // Config writes happen only in CMP and reloads only in UPD, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        deadline_q[i] <= '0;
        period_q[i]   <= '0;
      end
    end else if (cfg_fire && cfg_op == ALARM_OP_ARM) begin
      deadline_q[cfg_ch] <= cfg_deadline;
      period_q[cfg_ch]   <= cfg_period;
    end else if (fire && cur_period != '0) begin
      deadline_q[ptr_q] <= next_deadline;
    end
  end

  // A new hit beats a same-cycle acknowledge.
  always_comb begin
    armed_d   = armed_q;
    pending_d = pending_q & ~irq_ack;
    if (cfg_fire && cfg_op == ALARM_OP_ARM)    armed_d[cfg_ch] = 1'b1;
    if (cfg_fire && cfg_op == ALARM_OP_DISARM) armed_d[cfg_ch] = 1'b0;
    if (fire) begin
      pending_d[ptr_q] = 1'b1;
      if (cur_period == '0) armed_d[ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign armed       = armed_q;
  assign irq_pending = pending_q;
  assign irq         = irq_q;

`ifdef IOB_TIMER_ALARM_MISSCNT_EN
  logic [ALARM_MISS_W-1:0] miss_q [N_CH];

  // A miss is a hit landing on a flag software has not yet cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) miss_q[i] <= '0;
    end else if (cfg_fire && cfg_op == ALARM_OP_CLRMISS) begin
      miss_q[cfg_ch] <= '0;
    end else if (fire && pending_q[ptr_q] && !irq_ack[ptr_q]) begin
      miss_q[ptr_q] <= sat_inc(miss_q[ptr_q]);
    end
  end

  always_comb begin
    miss_cnt = '0;
    for (int c = 0; c < N_CH; c++) miss_cnt[c*ALARM_MISS_W +: ALARM_MISS_W] = miss_q[c];
  end
`endif

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Self-checking bench for iob_timer_alarm (N_CH=4); the miss-counter scenario
// runs only when IOB_TIMER_ALARM_MISSCNT_EN is defined.
module tb_iob_timer_alarm;
  import iob_timer_alarm_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 64;
  localparam int CH_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  timer_value = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_op = '0;
  logic [CNT_W-1:0]  cfg_deadline = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [N_CH-1:0]   irq_ack = '0;
  logic [N_CH-1:0]   irq_pending;
  logic              irq;
  logic [N_CH-1:0]   armed;
`ifdef IOB_TIMER_ALARM_MISSCNT_EN
  logic [8*N_CH-1:0] miss_cnt;
`endif

  int  n_vec = 0;
  int  n_err = 0;
  bit  ramp = 1'b0;
  logic [CNT_W-1:0] exp_q[$];

  iob_timer_alarm #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .timer_value  (timer_value),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_op       (cfg_op),
    .cfg_deadline (cfg_deadline),
    .cfg_period   (cfg_period),
    .irq_ack      (irq_ack),
    .irq_pending  (irq_pending),
    .irq          (irq),
    .armed        (armed)
`ifdef IOB_TIMER_ALARM_MISSCNT_EN
    ,
    .miss_cnt     (miss_cnt)
`endif
  );

  // ---------------- clock / reset / timer ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (ramp) timer_value = timer_value + 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [1:0] op,
                        input logic [CNT_W-1:0] dl, input logic [CNT_W-1:0] per);
    int n = 0;
    cfg_ch = ch; cfg_op = op; cfg_deadline = dl; cfg_period = per; cfg_valid = 1'b1;
    while (!cfg_ready && n < 10) begin tick(); n++; end
    n_vec++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_accept ch%0d: cfg_ready=%b after %0d cycles, required 1", ch, cfg_ready, n);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_fire(input int ch, input int max_cyc,
                           output logic [CNT_W-1:0] t, output bit ok);
    int n = 0;
    while (!irq_pending[ch] && n < max_cyc) begin tick(); n++; end
    ok = irq_pending[ch];
    t  = timer_value;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL fire_timeout ch%0d: pending=0 after %0d cycles, required 1", ch, max_cyc);
    end
  endtask

  task automatic ack_ch(input int ch);
    irq_ack[ch] = 1'b1;
    tick();
    irq_ack[ch] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) tick();
    n_vec += 4;
    if (irq_pending !== '0) begin n_err++; $display("FAIL reset_pending: got %b, required 0000", irq_pending); end
    if (irq !== 1'b0)       begin n_err++; $display("FAIL reset_irq: got %b, required 0", irq); end
    if (armed !== '0)       begin n_err++; $display("FAIL reset_armed: got %b, required 0000", armed); end
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
`ifdef IOB_TIMER_ALARM_MISSCNT_EN
    n_vec++;
    if (miss_cnt !== '0) begin n_err++; $display("FAIL reset_miss: got %h, required 0", miss_cnt); end
`endif
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (irq_pending !== '0) begin n_err++; $display("FAIL idle_pending: got %b, required 0000", irq_pending); end
  endtask

  task automatic test_one_shot();
    logic [CNT_W-1:0] t, exp;
    bit ok;
    int extra = 0;
    int n = 0;
    timer_value = '0;
    ramp = 1'b1;
    do_cfg(2'd2, ALARM_OP_ARM, 64'd100, 64'd0);
    exp_q.push_back(64'd100);
    wait_fire(2, 200, t, ok);
    exp = exp_q.pop_front();
    n_vec++;
    if (!ok || (t - exp) > 64'd10) begin
      n_err++; $display("FAIL oneshot_time: fired at timer=%0d, required %0d..%0d", t, exp, exp + 10);
    end
    tick();
    n_vec += 2;
    if (irq !== 1'b1)      begin n_err++; $display("FAIL oneshot_irq: got %b, required 1", irq); end
    if (armed[2] !== 1'b0) begin n_err++; $display("FAIL oneshot_disarm: armed[2]=%b, required 0", armed[2]); end
    ack_ch(2);
    while (timer_value < 64'd1000 && n < 1200) begin
      tick();
      if (irq_pending[2]) extra++;
      n++;
    end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL oneshot_refire: %0d pending cycles, required 0", extra); end
  endtask

  task automatic test_periodic();
    logic [CNT_W-1:0] t, exp;
    bit ok;
    timer_value = '0;
    do_cfg(2'd0, ALARM_OP_ARM, 64'd50, 64'd20);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'd50 + 64'(20 * i));
    for (int i = 0; i < 4; i++) begin
      wait_fire(0, 60, t, ok);
      exp = exp_q.pop_front();
      n_vec++;
      if (!ok || (t - exp) > 64'd10) begin
        n_err++; $display("FAIL periodic_time #%0d: fired at timer=%0d, required %0d..%0d", i, t, exp, exp + 10);
      end
      ack_ch(0);
    end
    n_vec++;
    if (armed[0] !== 1'b1) begin n_err++; $display("FAIL periodic_armed: armed[0]=%b, required 1", armed[0]); end
    do_cfg(2'd0, ALARM_OP_DISARM, '0, '0);
    n_vec++;
    if (armed[0] !== 1'b0) begin n_err++; $display("FAIL disarm: armed[0]=%b, required 0", armed[0]); end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] t, exp;
    bit ok;
    timer_value = 64'hFFFF_FFFF_FFFF_FFEC;
    do_cfg(2'd1, ALARM_OP_ARM, 64'hFFFF_FFFF_FFFF_FFF6, 64'd30);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF6);
    exp_q.push_back(64'd20);
    for (int i = 0; i < 2; i++) begin
      wait_fire(1, 60, t, ok);
      exp = exp_q.pop_front();
      n_vec++;
      if (!ok || (t - exp) > 64'd10) begin
        n_err++; $display("FAIL wrap_time #%0d: fired at timer=%h, required %h+0..10", i, t, exp);
      end
      ack_ch(1);
    end
    do_cfg(2'd1, ALARM_OP_DISARM, '0, '0);
  endtask

  task automatic test_hold_cfg();
    int n = 0;
    int n_xfer = 0;
    bit xfer;
    while (cfg_ready && n < 4) begin tick(); n++; end
    cfg_ch = 2'd3; cfg_op = 2'b11; cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer = cfg_valid && cfg_ready;
      if (xfer) n_xfer++;
      tick();
      if (xfer) begin
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hold_stay_cmp: cfg_ready=%b after transfer, required 1", cfg_ready); end
      end
    end
    cfg_valid = 1'b0;
    n_vec += 2;
    if (n_xfer != 1)       begin n_err++; $display("FAIL hold_xfers: got %0d transfers, required 1", n_xfer); end
    if (armed[3] !== 1'b0) begin n_err++; $display("FAIL reserved_op: armed[3]=%b, required 0", armed[3]); end
  endtask

  task automatic test_ack_collision();
    logic [CNT_W-1:0] t;
    bit ok;
    irq_ack[3] = 1'b1;
    do_cfg(2'd3, ALARM_OP_ARM, 64'd0, 64'd0);
    wait_fire(3, 12, t, ok);
    irq_ack[3] = 1'b0;
    tick();
    n_vec += 2;
    if (irq_pending[3] !== 1'b1) begin n_err++; $display("FAIL collide_pending: pending[3]=%b, required 1", irq_pending[3]); end
    if (irq !== 1'b1)            begin n_err++; $display("FAIL collide_irq: got %b, required 1", irq); end
    ack_ch(3);
    n_vec++;
    if (irq_pending[3] !== 1'b0) begin n_err++; $display("FAIL ack_clear: pending[3]=%b, required 0", irq_pending[3]); end
  endtask

  task automatic test_enable();
    logic [CNT_W-1:0] t;
    bit ok;
    int extra = 0;
    en = 1'b0;
    do_cfg(2'd1, ALARM_OP_ARM, 64'd0, 64'd0);
    repeat (30) begin
      tick();
      if (irq_pending[1]) extra++;
    end
    n_vec += 2;
    if (extra != 0)        begin n_err++; $display("FAIL frozen_fire: %0d pending cycles with en=0, required 0", extra); end
    if (armed[1] !== 1'b1) begin n_err++; $display("FAIL frozen_cfg: armed[1]=%b, required 1", armed[1]); end
    en = 1'b1;
    wait_fire(1, 12, t, ok);
    n_vec++;
    if (armed[1] !== 1'b0) begin n_err++; $display("FAIL resume_disarm: armed[1]=%b, required 0", armed[1]); end
    ack_ch(1);
  endtask

`ifdef IOB_TIMER_ALARM_MISSCNT_EN
  task automatic test_misscnt();
    ramp = 1'b0;
    timer_value = 64'd1000;
    do_cfg(2'd0, ALARM_OP_ARM, 64'd0, 64'd1);
    repeat (2200) tick();
    n_vec += 3;
    if (miss_cnt[7:0] !== 8'd255) begin n_err++; $display("FAIL miss_sat: got %0d, required 255", miss_cnt[7:0]); end
    if (miss_cnt[31:8] !== '0)    begin n_err++; $display("FAIL miss_others: got %h, required 0", miss_cnt[31:8]); end
    if (irq_pending[0] !== 1'b1)  begin n_err++; $display("FAIL miss_pending: got %b, required 1", irq_pending[0]); end
    do_cfg(2'd0, ALARM_OP_CLRMISS, '0, '0);
    n_vec++;
    if (miss_cnt[7:0] !== 8'd0) begin n_err++; $display("FAIL miss_clear: got %0d, required 0", miss_cnt[7:0]); end
    do_cfg(2'd0, ALARM_OP_DISARM, '0, '0);
    ack_ch(0);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_wrap();
    test_hold_cfg();
    test_ack_collision();
    test_enable();
`ifdef IOB_TIMER_ALARM_MISSCNT_EN
    test_misscnt();
`endif
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d expected fires left, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
